// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day controller.
package clock_pkg;

  localparam int unsigned SEC_PER_DAY = 86400;
  localparam int unsigned H_MAX       = 23;
  localparam int unsigned MS_MAX      = 59;
  localparam int unsigned SEC_PER_H   = 3600;
  localparam int unsigned SEC_PER_M   = 60;
  localparam int unsigned DAY_W       = $clog2(SEC_PER_DAY);
  localparam int unsigned H_W         = $clog2(H_MAX + 1);
  localparam int unsigned MS_W        = $clog2(MS_MAX + 1);
  localparam int unsigned MP_W        = 12;

  // Encoding doubles as the edit_sel display hint.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } tc_state_t;

  // h*3600 + m*60 + s with products sized so nothing is truncated.
  function automatic logic [DAY_W-1:0] to_sec(input logic [H_W-1:0]  h,
                                              input logic [MS_W-1:0] m,
                                              input logic [MS_W-1:0] s);
    logic [DAY_W-1:0] h_prod;
    logic [MP_W-1:0]  m_prod;
    h_prod = DAY_W'(h) * DAY_W'(SEC_PER_H);
    m_prod = MP_W'(m) * MP_W'(SEC_PER_M);
    return h_prod + DAY_W'(m_prod) + DAY_W'(s);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up/down counter with a look-ahead next value and carry-out.
module wrap_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59,
  localparam int unsigned W  = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic [W-1:0] next_c,
  output logic         carry_c
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Simultaneous inc and dec cancel; clr dominates.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && !dec) begin
      value_d = (value_q == W'(MAX)) ? '0 : value_q + W'(1);
    end else if (dec && !inc) begin
      value_d = (value_q == '0) ? W'(MAX) : value_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign next_c  = value_d;
  assign carry_c = inc && !dec && !clr && (value_q == W'(MAX));

endmodule

// File: rtl/time_ctrl.sv
// Time-of-day keeper with a mode/inc/dec field editor; drives seconds-of-day
// plus field-select and setting hints for the display.
module time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SEC_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_dec,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       edit_sel,
  output logic             setting
);

  tc_state_t        state_q;
  tc_state_t        state_d;
  logic [SEC_W-1:0] seconds_q;

  logic             edit_ok_c;
  logic             run_tick_c;
  logic             h_inc_c, h_dec_c, m_inc_c, m_dec_c, s_inc_c, s_dec_c;
  logic             h_carry_c, m_carry_c, s_carry_c;
  logic [H_W-1:0]   h_val, h_nxt_c;
  logic [MS_W-1:0]  m_val, m_nxt_c, s_val, s_nxt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        SET_S:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    edit_sel = state_q;
    setting  = (state_q != RUN);
  end

  // Mode press discards edits; inc with dec together cancels. Ticks only count in RUN.
  always_comb begin
    edit_ok_c  = !btn_mode && (btn_inc ^ btn_dec);
    run_tick_c = (state_q == RUN) && tick_1hz;
    s_inc_c    = run_tick_c || ((state_q == SET_S) && edit_ok_c && btn_inc);
    s_dec_c    = (state_q == SET_S) && edit_ok_c && btn_dec;
    m_inc_c    = (run_tick_c && s_carry_c) || ((state_q == SET_M) && edit_ok_c && btn_inc);
    m_dec_c    = (state_q == SET_M) && edit_ok_c && btn_dec;
    h_inc_c    = (run_tick_c && m_carry_c) || ((state_q == SET_H) && edit_ok_c && btn_inc);
    h_dec_c    = (state_q == SET_H) && edit_ok_c && btn_dec;
  end

  wrap_counter #(.MAX(MS_MAX)) u_sec (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (s_inc_c),
    .dec     (s_dec_c),
    .clr     (1'b0),
    .value   (s_val),
    .next_c  (s_nxt_c),
    .carry_c (s_carry_c)
  );

  wrap_counter #(.MAX(MS_MAX)) u_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (m_inc_c),
    .dec     (m_dec_c),
    .clr     (1'b0),
    .value   (m_val),
    .next_c  (m_nxt_c),
    .carry_c (m_carry_c)
  );

  wrap_counter #(.MAX(H_MAX)) u_hour (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (h_inc_c),
    .dec     (h_dec_c),
    .clr     (1'b0),
    .value   (h_val),
    .next_c  (h_nxt_c),
    .carry_c (h_carry_c)
  );

  // Built from the counters' next values so seconds stays coherent with the fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seconds_q <= '0;
    end else if (run_tick_c && h_carry_c) begin
      seconds_q <= '0;
    end else begin
      seconds_q <= SEC_W'(to_sec(h_nxt_c, m_nxt_c, s_nxt_c));
    end
  end

  assign seconds = seconds_q;

  logic unused_c;
  assign unused_c = ^{h_val, m_val, s_val};

endmodule

// File: tb/tb_time_ctrl.sv
// Self-checking bench for time_ctrl: seconds-of-day reference model plus
// directed scenarios with literal expectations.
module tb_time_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic [16:0] seconds;
  logic [1:0]  edit_sel;
  logic        setting;

  int checks = 0;
  int failures = 0;
  int mdl_tot;
  int mdl_mode;

  always #5 clk = ~clk;

  time_ctrl #(.SEC_W(17)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .seconds  (seconds),
    .edit_sel (edit_sel),
    .setting  (setting)
  );

  // Reference: whole clock as a seconds-of-day integer, fields split out only to edit.
  function automatic int model_next(input int tot, input int mode, input logic t,
                                    input logic md, input logic inc, input logic dec);
    int hh, mm, ss, dl;
    if (mode == 0) begin
      return t ? (tot + 1) % 86400 : tot;
    end
    if (md || (inc == dec)) return tot;
    hh = tot / 3600;
    mm = (tot / 60) % 60;
    ss = tot % 60;
    dl = inc ? 1 : -1;
    case (mode)
      1:       hh = (hh + dl + 24) % 24;
      2:       mm = (mm + dl + 60) % 60;
      default: ss = (ss + dl + 60) % 60;
    endcase
    return hh * 3600 + mm * 60 + ss;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_tot  <= 0;
      mdl_mode <= 0;
    end else begin
      mdl_tot  <= model_next(mdl_tot, mdl_mode, tick_1hz, btn_mode, btn_inc, btn_dec);
      mdl_mode <= btn_mode ? (mdl_mode + 1) % 4 : mdl_mode;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("model_seconds", int'(seconds), mdl_tot);
    chk("model_edit_sel", int'(edit_sel), mdl_mode);
    chk("model_setting", int'(setting), (mdl_mode != 0) ? 1 : 0);
  endtask

  // Drive one cycle of inputs at the falling edge, then compare after the rising edge.
  task automatic cyc(input logic t, input logic md, input logic inc, input logic dec);
    tick_1hz = t;
    btn_mode = md;
    btn_inc  = inc;
    btn_dec  = dec;
    @(negedge clk);
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    cmp_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sel[4];
    int exp_set[4];
    exp_sel = '{1, 2, 3, 0};
    exp_set = '{1, 1, 1, 0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_seconds", int'(seconds), 0);
    chk("reset_edit_sel", int'(edit_sel), 0);
    chk("reset_setting", int'(setting), 0);
    cmp_model();

    repeat (3) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("three_ticks", int'(seconds), 3);

    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("enter_set_h_sel", int'(edit_sel), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seconds", int'(seconds), 0);
    chk("async_rst_edit_sel", int'(edit_sel), 0);
    chk("async_rst_setting", int'(setting), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_model();

    // Build 23:59:58 through the editor, exercising wraps and priority on the way.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("h_dec_wrap", int'(seconds), 82800);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("inc_dec_cancel", int'(seconds), 82800);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("mode_beats_inc_sec", int'(seconds), 82800);
    chk("mode_beats_inc_sel", int'(edit_sel), 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("m_dec_wrap", int'(seconds), 86340);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("m_inc_wrap", int'(seconds), 82800);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause_in_set_m", int'(seconds), 86340);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("set_s_sel", int'(edit_sel), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("s_dec_wrap", int'(seconds), 86399);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("s_dec", int'(seconds), 86398);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tick_on_exit_ignored", int'(seconds), 86398);
    chk("back_to_run_sel", int'(edit_sel), 0);
    chk("back_to_run_setting", int'(setting), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tick_to_last_sec", int'(seconds), 86399);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("day_wrap", int'(seconds), 0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("run_ignores_inc", int'(seconds), 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("mode_cycle_sel", int'(edit_sel), exp_sel[i]);
      chk("mode_cycle_setting", int'(setting), exp_set[i]);
    end

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("back_to_back_ticks", int'(seconds), 3);

    repeat (400) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
